// File: rtl/imem_loader.sv
// imem_loader: dual-port instruction memory with registered fetch, byte-enable
// direct write and a byte-stream loader that packs little-endian words.
module imem_loader #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    localparam int NB    = DATA_W / 8,
    localparam int IW    = $clog2(DEPTH),
    localparam int OFS   = $clog2(NB)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid,
    output logic              fetch_err,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [NB-1:0]     wr_be,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [IW:0]       load_len,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    output logic              ld_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;

    state_t              r_state, w_next;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_fetch_data;
    logic                r_fetch_valid, r_fetch_err;
    logic [IW-1:0]       r_ptr;
    logic [IW:0]         r_left;
    logic [OFS:0]        r_bcnt;
    logic [DATA_W-1:0]   r_word;
    logic                r_err;

    logic                w_busy, w_fetch_ok, w_fetch_in, w_wr_in, w_base_in, w_load_bad;
    logic [IW-1:0]       w_fetch_idx, w_wr_idx, w_base_idx, w_waddr;
    logic [IW+1:0]       w_load_end;
    logic [NB-1:0]       w_we;
    logic [DATA_W-1:0]   w_wdata;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a >> (OFS + IW)) == '0;
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return a[OFS+IW-1:OFS];
    endfunction

    assign w_busy      = r_state != S_IDLE;
    assign w_fetch_in  = in_range(fetch_addr);
    assign w_wr_in     = in_range(wr_addr);
    assign w_base_in   = in_range(load_base);
    assign w_fetch_idx = word_idx(fetch_addr);
    assign w_wr_idx    = word_idx(wr_addr);
    assign w_base_idx  = word_idx(load_base);
    assign w_fetch_ok  = fetch_en && !w_busy;
    assign w_load_end  = {2'b00, w_base_idx} + {1'b0, load_len};
    assign w_load_bad  = !w_base_in || (w_load_end > (IW+2)'(DEPTH));

    // Loader and direct writes are mutually exclusive (direct needs !busy), so one port serves both
    assign w_we    = (r_state == S_WRITE) ? '1 : (wr_en && !w_busy && w_wr_in) ? wr_be : '0;
    assign w_waddr = (r_state == S_WRITE) ? r_ptr : w_wr_idx;
    assign w_wdata = (r_state == S_WRITE) ? r_word : wr_data;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++)
            if (w_we[i]) r_mem[w_waddr][i*8 +: 8] <= w_wdata[i*8 +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_data  <= '0;
            r_fetch_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
        end else begin
            r_fetch_valid <= w_fetch_ok;
            r_fetch_err   <= w_fetch_ok && !w_fetch_in;
            if (w_fetch_ok) r_fetch_data <= w_fetch_in ? r_mem[w_fetch_idx] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (load_start && !w_load_bad) w_next = (load_len == '0) ? S_DONE : S_RECV;
            S_RECV:  if (ld_valid && r_bcnt == (OFS+1)'(NB-1)) w_next = S_WRITE;
            S_WRITE: w_next = (r_left == (IW+1)'(1)) ? S_DONE : S_RECV;
            S_DONE:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr  <= '0;
            r_left <= '0;
            r_bcnt <= '0;
            r_word <= '0;
            r_err  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && load_start) begin
                r_err <= w_load_bad;
                if (!w_load_bad) begin
                    r_ptr  <= w_base_idx;
                    r_left <= load_len;
                    r_bcnt <= '0;
                end
            end
            if (r_state == S_RECV && ld_valid) begin
                r_word[8*int'(r_bcnt) +: 8] <= ld_data;
                r_bcnt                      <= r_bcnt + 1'b1;
            end
            if (r_state == S_WRITE) begin
                r_ptr  <= r_ptr + 1'b1;
                r_left <= r_left - 1'b1;
                r_bcnt <= '0;
            end
        end
    end

    assign fetch_data  = r_fetch_data;
    assign fetch_valid = r_fetch_valid;
    assign fetch_err   = r_fetch_err;
    assign ld_ready    = r_state == S_RECV;
    assign busy        = w_busy;
    assign done        = r_state == S_DONE;
    assign err         = r_err;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of fetch, byte-enable writes, streamed loads,
// range errors, read-first collisions and reset during a load.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en, wr_en, load_start, ld_valid;
    logic [31:0] fetch_addr, wr_addr, wr_data, load_base;
    logic [3:0]  wr_be;
    logic [10:0] load_len;
    logic [7:0]  ld_data;
    logic [31:0] fetch_data;
    logic        fetch_valid, fetch_err, ld_ready, busy, done, err;
    int          n = 0;
    int          errs = 0;
    int          done_cnt = 0;
    int          d0, k;

    imem_loader dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_en(fetch_en), .fetch_addr(fetch_addr), .fetch_data(fetch_data),
        .fetch_valid(fetch_valid), .fetch_err(fetch_err),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .load_start(load_start), .load_base(load_base), .load_len(load_len),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic fetch_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        fetch_en = 1'b1; fetch_addr = a;
        tick();
        fetch_en = 1'b0;
        chk({tag, "_valid"}, {31'b0, fetch_valid}, 32'd1);
        chk({tag, "_err"}, {31'b0, fetch_err}, 32'd0);
        chk(tag, fetch_data, exp);
    endtask

    task automatic start(input logic [31:0] base, input logic [10:0] len);
        load_start = 1'b1; load_base = base; load_len = len;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int w = 0;
        ld_valid = 1'b1; ld_data = b;
        while (!ld_ready && w < 20) begin
            tick();
            w++;
        end
        chk("ld_ready_wait", {31'b0, ld_ready}, 32'd1);
        tick();
        ld_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] prog [8];
        prog = '{8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'h70, 8'h00};
        rst_n = 1'b0; fetch_en = 0; wr_en = 0; load_start = 0; ld_valid = 0;
        fetch_addr = 0; wr_addr = 0; wr_data = 0; wr_be = 0; load_base = 0; load_len = 0; ld_data = 0;
        #3;
        chk("rst_fetch_data", fetch_data, 0);
        chk("rst_fetch_valid", {31'b0, fetch_valid}, 0);
        chk("rst_fetch_err", {31'b0, fetch_err}, 0);
        chk("rst_ld_ready", {31'b0, ld_ready}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_err", {31'b0, err}, 0);
        tick();
        rst_n = 1'b1;
        tick();

        wr(32'h0, 32'h00500113, 4'hF);
        wr(32'h4, 32'h00700193, 4'hF);
        wr(32'h8, 32'h00310233, 4'hF);
        wr(32'hC, 32'h0000006F, 4'hF);
        fetch_chk("fetch_8", 32'h8, 32'h00310233);
        tick();
        chk("idle_valid", {31'b0, fetch_valid}, 0);
        chk("idle_hold", fetch_data, 32'h00310233);
        fetch_chk("fetch_c", 32'hC, 32'h0000006F);

        wr(32'h10, 32'hAABBCCDD, 4'hF);
        wr(32'h10, 32'h11223344, 4'h5);
        fetch_chk("byte_en", 32'h10, 32'hAA22CC44);

        d0 = done_cnt;
        start(32'h40, 11'd2);
        fetch_en = 1'b1; fetch_addr = 32'h40;
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 2)) begin
                tick();
                chk("load_busy", {31'b0, busy}, 1);
                chk("load_fetch_gated", {31'b0, fetch_valid}, 0);
            end
            send(prog[i]);
            chk("load_busy_b", {31'b0, busy}, 1);
            chk("load_fetch_gated_b", {31'b0, fetch_valid}, 0);
        end
        k = 0;
        while (busy && k < 20) begin
            chk("load_fetch_gated_t", {31'b0, fetch_valid}, 0);
            tick();
            k++;
        end
        fetch_en = 1'b0;
        chk("load_end_busy", {31'b0, busy}, 0);
        chk("load_done_count", done_cnt - d0, 1);
        fetch_chk("load_w0", 32'h40, 32'h00500113);
        fetch_chk("load_w1", 32'h44, 32'h00700193);

        wr(32'hFFC, 32'hDEADBEEF, 4'hF);
        d0 = done_cnt;
        start(32'hFFC, 11'd2);
        ld_valid = 1'b1; ld_data = 8'h55;
        chk("range_err", {31'b0, err}, 1);
        chk("range_busy", {31'b0, busy}, 0);
        chk("range_ready", {31'b0, ld_ready}, 0);
        tick();
        tick();
        ld_valid = 1'b0;
        chk("range_busy2", {31'b0, busy}, 0);
        chk("range_err_sticky", {31'b0, err}, 1);
        chk("range_no_done", done_cnt - d0, 0);
        fetch_chk("range_mem", 32'hFFC, 32'hDEADBEEF);
        start(32'h0, 11'd0);
        chk("zero_err_clr", {31'b0, err}, 0);
        chk("zero_done", {31'b0, done}, 1);
        chk("zero_busy", {31'b0, busy}, 1);
        tick();
        chk("zero_done_off", {31'b0, done}, 0);
        chk("zero_idle", {31'b0, busy}, 0);
        start(32'hFFC, 11'd1);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        tick();
        tick();
        chk("last_word_err", {31'b0, err}, 0);
        fetch_chk("last_word", 32'hFFC, 32'hDDCCBBAA);

        fetch_en = 1'b1; fetch_addr = 32'h0;
        wr_en = 1'b1; wr_addr = 32'h0; wr_data = 32'hCAFEF00D; wr_be = 4'hF;
        tick();
        fetch_en = 1'b0; wr_en = 1'b0;
        chk("coll_old", fetch_data, 32'h00500113);
        fetch_chk("coll_new", 32'h0, 32'hCAFEF00D);
        wr(32'h1000, 32'h12345678, 4'hF);
        fetch_chk("oor_write_ignored", 32'h0, 32'hCAFEF00D);
        fetch_en = 1'b1; fetch_addr = 32'h1000;
        tick();
        fetch_en = 1'b0;
        chk("oor_valid", {31'b0, fetch_valid}, 1);
        chk("oor_err", {31'b0, fetch_err}, 1);
        chk("oor_data", fetch_data, 0);
        tick();
        chk("oor_err_clr", {31'b0, fetch_err}, 0);

        wr(32'h80, 32'h11111111, 4'hF);
        wr(32'h84, 32'h22222222, 4'hF);
        fetch_chk("pre_rst", 32'h84, 32'h22222222);
        start(32'h80, 11'd2);
        for (int i = 1; i <= 5; i++) send(8'(i));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'b0, busy}, 0);
        chk("mid_rst_ready", {31'b0, ld_ready}, 0);
        chk("mid_rst_done", {31'b0, done}, 0);
        chk("mid_rst_err", {31'b0, err}, 0);
        chk("mid_rst_fvalid", {31'b0, fetch_valid}, 0);
        chk("mid_rst_fdata", fetch_data, 0);
        tick();
        rst_n = 1'b1;
        tick();
        fetch_chk("mid_rst_w0", 32'h80, 32'h04030201);
        fetch_chk("mid_rst_w1", 32'h84, 32'h22222222);
        start(32'h0, 11'd0);
        chk("post_rst_done", {31'b0, done}, 1);
        tick();
        chk("post_rst_done_off", {31'b0, done}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Parametrised dual-port instruction memory with a built-in byte-stream program loader.
- Port A: registered instruction fetch for the core.
- Port B: direct word write with byte enables.
- Loader: accepts a byte stream (e.g. from the UART bridge) over a valid/ready handshake, packs bytes into words and writes them sequentially from a base address. Fetch is gated while a load is in progress.

Parameters:
- DEPTH, 1024, number of words; power of two, ≥ 4.
- DATA_W, 32, word width in bits; multiple of 8. NB = DATA_W/8 bytes per word.
- ADDR_W, 32, byte-address width of the fetch, write and load-base ports.
- IW, derived = $clog2(DEPTH), word-index width. OFS, derived = $clog2(NB).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- fetch_en  in  1  fetch request
- fetch_addr  in  ADDR_W  byte address of instruction
- fetch_data  out  DATA_W  fetched word
- fetch_valid  out  1  fetch_data valid this cycle
- fetch_err  out  1  fetch address out of range (qualifies fetch_valid)
- wr_en  in  1  direct write strobe
- wr_addr  in  ADDR_W  byte address of direct write
- wr_data  in  DATA_W  direct write data
- wr_be  in  NB  byte-lane enables
- load_start  in  1  start a load (pulse)
- load_base  in  ADDR_W  byte address of first word
- load_len  in  IW+1  number of words to load
- ld_valid  in  1  stream byte valid
- ld_data  in  8  stream byte
- ld_ready  out  1  loader accepts byte
- busy  out  1  load in progress
- done  out  1  one-cycle pulse at load completion
- err  out  1  sticky load-range error

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: fetch_data=0, fetch_valid=0, fetch_err=0, ld_ready=0, busy=0, done=0, err=0.
  - FSM returns to IDLE.
  - Memory array is not reset and has no initial contents.
  - Reset asserted mid-load aborts the load; words already written stay written.
- Word index: addr[OFS+IW-1:OFS]. Address is out of range if any bit at or above OFS+IW is set. Low OFS bits are ignored.
- Fetch:
  - fetch_en=1 and busy=0 at edge N → fetch_valid=1 at N+1, with fetch_data = memory word.
  - Out-of-range fetch → fetch_data=0, fetch_err=1.
  - fetch_en=0, or busy=1 → fetch_valid=0, fetch_err=0; fetch_data holds its last value.
- Direct write:
  - Acts when wr_en=1, busy=0 and address in range. Only lanes with wr_be[i]=1 are updated.
  - Ignored while busy or when out of range.
- Same-cycle read/write to one word (either write source): read-first, so the fetch returns old data.
- FSM states: IDLE, RECV, WRITE, DONE.
- IDLE:
  - load_start=1 with base+len > DEPTH (word units) → err=1, stay IDLE, no done pulse.
  - load_start=1 with load_len=0 → err=0, go to DONE.
  - Otherwise: err=0, ptr = base index, left = load_len, bcnt=0, go to RECV.
  - load_start outside IDLE is ignored.
- RECV:
  - ld_ready=1.
  - On ld_valid & ld_ready: ld_data is placed in lane bcnt (little-endian; first byte → bits[7:0]) and bcnt increments.
  - When the NB-th byte is accepted, go to WRITE.
- WRITE:
  - ld_ready=0. Full word is written at ptr; ptr+1, left-1, bcnt=0.
  - left becomes 0 → DONE; otherwise → RECV.
  - Throughput: NB+1 cycles per word minimum.
- DONE: done=1 for one cycle, then go to IDLE.
- busy = 1 in RECV, WRITE and DONE. ld_ready is 0 outside RECV.
- ld_valid outside RECV: byte is not consumed; the source holds it.

Test Plan:
- Reset, then direct writes of 0x00500113, 0x00700193, 0x00310233, 0x0000006F to addrs 0x0/0x4/0x8/0xC with wr_be=0xF; fetch 0x8 → fetch_valid next cycle, fetch_data=0x00310233.
- Byte enables: write 0xAABBCCDD then 0x11223344 with wr_be=0x5 to addr 0x10 → fetch returns 0xAA22CC44.
- Load: base=0x40, len=2, stream 13 01 50 00 93 01 70 00 with random ld_valid gaps → busy high throughout, fetch_valid=0 while busy, done pulse once; fetch 0x40=0x00500113, 0x44=0x00700193.
- Range: base=0xFFC (word 1023), len=2 → err=1, busy stays 0, no done, memory unchanged; next valid load_start clears err.
- Collision and out-of-range: fetch and direct write to the same word in one cycle → old data returned; fetch 0x1000 → fetch_data=0, fetch_err=1.
- Reset mid-load after 5 bytes of len=2 → outputs return to reset values immediately; word 0 written, word 1 untouched; a following load_len=0 gives a done pulse the cycle after.
